// File: rtl/gates_unit.sv
// Registered AND/OR/NOT/NAND/NOR/XOR/XNOR of a and b. Results appear 1 cycle after in_valid and hold otherwise.
// There is no backpressure: one capture per cycle. Defining GATES_PARITY_EN adds parity_o = ^(a ^ b).
module gates_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] not_o,
    output logic [WIDTH-1:0] nand_o,
    output logic [WIDTH-1:0] nor_o,
    output logic [WIDTH-1:0] xor_o,
`ifdef GATES_PARITY_EN
    output logic [WIDTH-1:0] xnor_o,
    output logic             parity_o
`else
    output logic [WIDTH-1:0] xnor_o
`endif
);

    logic             vld_q;
    logic [WIDTH-1:0] and_q,  and_d;
    logic [WIDTH-1:0] or_q,   or_d;
    logic [WIDTH-1:0] not_q,  not_d;
    logic [WIDTH-1:0] nand_q, nand_d;
    logic [WIDTH-1:0] nor_q,  nor_d;
    logic [WIDTH-1:0] xor_q,  xor_d;
    logic [WIDTH-1:0] xnor_q, xnor_d;

    always_comb begin
        and_d  = a & b;
        or_d   = a | b;
        not_d  = ~a;
        nand_d = ~(a & b);
        nor_d  = ~(a | b);
        xor_d  = a ^ b;
        xnor_d = ~(a ^ b);
    end

    // Inverting results reset to 0 as well, so they are stored, not derived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            and_q  <= '0;
            or_q   <= '0;
            not_q  <= '0;
            nand_q <= '0;
            nor_q  <= '0;
            xor_q  <= '0;
            xnor_q <= '0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                and_q  <= and_d;
                or_q   <= or_d;
                not_q  <= not_d;
                nand_q <= nand_d;
                nor_q  <= nor_d;
                xor_q  <= xor_d;
                xnor_q <= xnor_d;
            end
        end
    end

`ifdef GATES_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = ^(a ^ b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (in_valid) begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;
`endif

    assign out_valid = vld_q;
    assign and_o     = and_q;
    assign or_o      = or_q;
    assign not_o     = not_q;
    assign nand_o    = nand_q;
    assign nor_o     = nor_q;
    assign xor_o     = xor_q;
    assign xnor_o    = xnor_q;

endmodule

// File: tb/tb_gates_unit.sv
// Directed bench for gates_unit at WIDTH 1, 8 and 4; parity checks follow GATES_PARITY_EN.
module tb_gates_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;

    logic       ov1, and1, or1, not1, nand1, nor1, xor1, xnor1;
    logic       ov8, ov4;
    logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
    logic [3:0] and4, or4, not4, nand4, nor4, xor4, xnor4;
`ifdef GATES_PARITY_EN
    logic       par1, par8, par4;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gates_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
        .out_valid(ov1), .and_o(and1), .or_o(or1), .not_o(not1), .nand_o(nand1),
        .nor_o(nor1), .xor_o(xor1),
`ifdef GATES_PARITY_EN
        .xnor_o(xnor1), .parity_o(par1)
`else
        .xnor_o(xnor1)
`endif
    );

    gates_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
        .out_valid(ov8), .and_o(and8), .or_o(or8), .not_o(not8), .nand_o(nand8),
        .nor_o(nor8), .xor_o(xor8),
`ifdef GATES_PARITY_EN
        .xnor_o(xnor8), .parity_o(par8)
`else
        .xnor_o(xnor8)
`endif
    );

    gates_unit #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
        .out_valid(ov4), .and_o(and4), .or_o(or4), .not_o(not4), .nand_o(nand4),
        .nor_o(nor4), .xor_o(xor4),
`ifdef GATES_PARITY_EN
        .xnor_o(xnor4), .parity_o(par4)
`else
        .xnor_o(xnor4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed width-1 result in order AND OR NOT NAND NOR XOR XNOR.
    function automatic logic [6:0] pack1();
        return {and1, or1, not1, nand1, nor1, xor1, xnor1};
    endfunction

    logic [1:0] tt_ab  [4];
    logic [6:0] tt_exp [4];

    initial begin
        tt_ab[0] = 2'b00; tt_exp[0] = 7'b0011101;
        tt_ab[1] = 2'b10; tt_exp[1] = 7'b0101010;
        tt_ab[2] = 2'b11; tt_exp[2] = 7'b1100001;
        tt_ab[3] = 2'b01; tt_exp[3] = 7'b0111010;

        // Reset asserted from time 0 with live inputs: checked before any edge and after several.
        rst_n = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hF0; b8 = 8'hAA; a4 = 4'hA; b4 = 4'h3;
        #2;
        check("rst_pre_edge_w1", {ov1, pack1()}, 8'h00);
        repeat (3) step();
        check("rst_w1", {ov1, pack1()}, 8'h00);
        check("rst_w8_and_or_not", {ov8, and8, or8, not8}, 25'h0);
        check("rst_w8_nand_nor_xor_xnor", {nand8, nor8, xor8, xnor8}, 32'h0);
        check("rst_w4", {ov4, and4, or4, not4, nand4, nor4, xor4, xnor4}, 29'h0);
`ifdef GATES_PARITY_EN
        check("rst_parity", {par1, par8, par4}, 3'b000);
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_after_rst_ov", ov1, 1'b0);

        // Width-1 truth table, one capture per vector.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_ab[i][1]; b1 = tt_ab[i][0]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("tt%0d_ov", i), ov1, 1'b1);
            check($sformatf("tt%0d_res", i), pack1(), tt_exp[i]);
        end

        // Hold: outputs keep a=1,b=0 results while inputs change with in_valid low.
        a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1;
        check("hold_cap_ov", ov1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_ov", i), ov1, 1'b0);
            check($sformatf("hold%0d_res", i), pack1(), 7'b0101010);
        end

        // Wide lanes and width-4 parity vector together.
        a8 = 8'hF0; b8 = 8'hAA; a4 = 4'b1010; b4 = 4'b0011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("w8_ov", ov8, 1'b1);
        check("w8_and", and8, 8'hA0);
        check("w8_or", or8, 8'hFA);
        check("w8_not", not8, 8'h0F);
        check("w8_nand", nand8, 8'h5F);
        check("w8_nor", nor8, 8'h05);
        check("w8_xor", xor8, 8'h5A);
        check("w8_xnor", xnor8, 8'hA5);
        check("w4_xor", xor4, 4'b1001);
`ifdef GATES_PARITY_EN
        check("w8_parity", par8, 1'b0);
        check("w4_parity0", par4, 1'b0);
`endif
        a4 = 4'b1000; b4 = 4'b0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("w4_xor_b", xor4, 4'b1000);
        check("w4_not_b", not4, 4'b0111);
`ifdef GATES_PARITY_EN
        check("w4_parity1", par4, 1'b1);
`endif

        // Mid-stream reset during the third of four back-to-back captures.
        a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
        step();
        check("ms_cap1", {ov1, pack1()}, {1'b1, 7'b1100001});
        a1 = 1'b1; b1 = 1'b0;
        step();
        check("ms_cap2", {ov1, pack1()}, {1'b1, 7'b0101010});
        a1 = 1'b1; b1 = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("ms_rst_w1", {ov1, pack1()}, 8'h00);
        check("ms_rst_w8", {ov8, and8, or8, not8, nand8, nor8, xor8, xnor8}, 57'h0);
`ifdef GATES_PARITY_EN
        check("ms_rst_parity", {par1, par8, par4}, 3'b000);
`endif
        rst_n = 1'b1;
        step();
        check("ms_post_and", and1, 1'b1);
        check("ms_post_ov", ov1, 1'b1);
        check("ms_post_nand", nand1, 1'b0);
        a1 = 1'b0; b1 = 1'b1;
        step();
        in_valid = 1'b0;
        check("ms_cap4", {ov1, pack1()}, {1'b1, 7'b0111010});
        step();
        check("ms_end_ov", ov1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
